// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory read port, redirect input and decode handshake.
// The sequencer takes the master view; the environment around it takes the slave view.
interface fetch_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              halted;
  logic              misalign_err;

  modport master (
    input  fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    output imem_addr, id_valid, id_instr, id_pc, halted, misalign_err
  );

  modport slave (
    output fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    input  imem_addr, id_valid, id_instr, id_pc, halted, misalign_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational imem and
// buffers {pc, instr} pairs in a small FIFO feeding decode; handles redirect/flush.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(28),
  parameter int                FQ_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.master bus
);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } fq_entry_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              err, err_n;
  logic              enq, deq, redir, flush;
  fq_entry_t         fq [FQ_DEPTH];

  assign deq   = bus.id_valid & bus.id_ready;
  assign redir = bus.redirect_valid & (state != IDLE);
  assign enq   = (state == RUN) & bus.fetch_en & ((count < CNT_W'(FQ_DEPTH)) | deq)
               & ~bus.redirect_valid;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    err_n   = err;
    flush   = 1'b0;
    count_n = count + CNT_W'(enq) - CNT_W'(deq);
    if (enq) pc_n = pc + ADDR_W'(4);
    case (state)
      IDLE:    if (bus.fetch_en) state_n = RUN;
      RUN:     if (enq && pc == PC_LIMIT) state_n = DRAIN;
      DRAIN:   if (count_n == '0) state_n = HALTED;
      default: state_n = state;
    endcase
    // Redirect wins over everything; a same-cycle dequeue still counts as accepted.
    if (redir) begin
      flush   = 1'b1;
      count_n = '0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        err_n   = 1'b1;
        state_n = HALTED;
      end else begin
        pc_n    = bus.redirect_pc;
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      count <= count_n;
      err   <= err_n;
    end
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) fq[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) begin
        fq[wr_ptr] <= '{pc: pc, instr: bus.imem_instr};
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.id_valid     = (count != '0);
  assign bus.id_instr     = fq[rd_ptr].instr;
  assign bus.id_pc        = fq[rd_ptr].pc;
  assign bus.halted       = (state == HALTED);
  assign bus.misalign_err = err;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, backpressure, redirect flush,
// misaligned redirect, pause/restart and asynchronous reset.
module tb_fetch_sequencer;
  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] acc [$];

  localparam logic [31:0] ROM [8] = '{
    32'h00221820, 32'h8C430004, 32'hAC640008, 32'h10A6FFFD,
    32'h00E83822, 32'h2129000C, 32'h0800000A, 32'h014B6024
  };

  fetch_if #(.ADDR_W(32)) bus ();

  fetch_sequencer #(
    .ADDR_W  (32),
    .RESET_PC(32'd0),
    .PC_LIMIT(32'd28),
    .FQ_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a <= 32'd28) return ROM[a[4:2]];
    return {16'hDEAD, a[15:0]};
  endfunction

  assign bus.imem_instr = instr_of(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records the head as accepted when the handshake completes at the coming edge.
  task automatic tick_rec();
    if (bus.id_valid && bus.id_ready) acc.push_back(bus.id_pc);
    tick();
  endtask

  task automatic do_reset();
    bus.redirect_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n              = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // 1. reset values, then streaming fetch 0..28 and halt
    tick();
    tick();
    chk("rst_addr",   bus.imem_addr, 32'd0);
    chk("rst_valid",  32'(bus.id_valid), 32'd0);
    chk("rst_instr",  bus.id_instr, 32'd0);
    chk("rst_pc",     bus.id_pc, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_err",    32'(bus.misalign_err), 32'd0);
    bus.fetch_en = 1'b1;
    bus.id_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("t1_valid_c1", 32'(bus.id_valid), 32'd0);
    tick();
    chk("t1_instr0", bus.id_instr, 32'h00221820);
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", 32'(bus.id_valid), 32'd1);
      chk("t1_pc", bus.id_pc, 32'(4 * i));
      chk("t1_instr", bus.id_instr, ROM[i]);
      tick();
    end
    chk("t1_halted", 32'(bus.halted), 32'd1);
    chk("t1_valid_end", 32'(bus.id_valid), 32'd0);
    chk("t1_addr_end", bus.imem_addr, 32'd32);

    // 2. backpressure
    bus.id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_pc", bus.id_pc, 32'd0);
      chk("t2_hold_valid", 32'(bus.id_valid), 32'd1);
      tick();
    end
    chk("t2_hold_addr", bus.imem_addr, 32'd8);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_seq_pc", bus.id_pc, 32'(4 * i));
      chk("t2_seq_instr", bus.id_instr, ROM[i]);
      tick();
    end

    // 3a. redirect flush while decode stalls
    bus.id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk("t3_full_addr", bus.imem_addr, 32'd8);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd16;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("t3_redir_addr", bus.imem_addr, 32'd16);
    bus.id_ready = 1'b1;
    tick();
    chk("t3_new_valid", 32'(bus.id_valid), 32'd1);
    chk("t3_new_pc", bus.id_pc, 32'd16);
    chk("t3_new_instr", bus.id_instr, ROM[4]);

    // 3b. redirect coinciding with an accepted dequeue
    bus.id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    acc.delete();
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd16;
    tick_rec();
    bus.redirect_valid = 1'b0;
    chk("t3b_flush_valid", 32'(bus.id_valid), 32'd0);
    tick_rec();
    chk("t3b_new_pc", bus.id_pc, 32'd16);
    tick_rec();
    chk("t3b_acc_n", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) begin
      chk("t3b_acc0", acc[0], 32'd0);
      chk("t3b_acc1", acc[1], 32'd16);
    end

    // 4. misaligned redirect, then aligned recovery
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h6;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t4_err", 32'(bus.misalign_err), 32'd1);
    chk("t4_halted", 32'(bus.halted), 32'd1);
    chk("t4_valid", 32'(bus.id_valid), 32'd0);
    chk("t4_pc_kept", bus.imem_addr, 32'd4);
    tick();
    tick();
    chk("t4_still_halted", 32'(bus.halted), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t4_resume_halted", 32'(bus.halted), 32'd0);
    chk("t4_resume_addr", bus.imem_addr, 32'd0);
    chk("t4_err_sticky", 32'(bus.misalign_err), 32'd1);
    tick();
    chk("t4_resume_pc", bus.id_pc, 32'd0);
    chk("t4_resume_valid", 32'(bus.id_valid), 32'd1);

    // 5. pause mid-run, then restart from HALTED
    do_reset();
    tick();
    tick();
    tick();
    tick();
    chk("t5_head8", bus.id_pc, 32'd8);
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_pause_addr", bus.imem_addr, 32'd12);
    end
    chk("t5_drained", 32'(bus.id_valid), 32'd0);
    bus.fetch_en = 1'b1;
    tick();
    chk("t5_resume_pc", bus.id_pc, 32'd12);
    n = 0;
    while (!bus.halted && n < 40) begin
      tick();
      n++;
    end
    chk("t5_halt1", 32'(bus.halted), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd8;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_restart_halted", 32'(bus.halted), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_restart_pc", bus.id_pc, 32'(8 + 4 * k));
      chk("t5_restart_valid", 32'(bus.id_valid), 32'd1);
    end
    tick();
    chk("t5_halt2", 32'(bus.halted), 32'd1);

    // 6. asynchronous reset with a full queue at pc 12
    bus.id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    tick();
    chk("t6_pre_addr", bus.imem_addr, 32'd12);
    chk("t6_pre_pc", bus.id_pc, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.id_valid), 32'd0);
    chk("t6_async_addr", bus.imem_addr, 32'd0);
    chk("t6_async_halted", 32'(bus.halted), 32'd0);
    chk("t6_async_pc", bus.id_pc, 32'd0);
    tick();
    bus.id_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("t6_rel_valid", 32'(bus.id_valid), 32'd0);
    tick();
    chk("t6_rel_pc0", bus.id_pc, 32'd0);
    tick();
    chk("t6_rel_pc4", bus.id_pc, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
